multi_port_sram_behavioral: RTL
===============================

MULTI_PORT_SRAM_BEHAVIORAL -- requirements
Module: multi_port_sram_behavioral

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 2, meaning the number of independent OBI-style read/write ports (1..8).
REQ-002 SHALL have parameter MEM_SIZE_BYTE, default 32768, meaning the memory capacity in bytes (power of two, at least 16).
REQ-003 SHALL have parameter PIPELINED, default 0, meaning 0 = one outstanding request per port and 1 = back-to-back requests per port.
REQ-004 SHALL have port clk_i, input, 1 bit, clock; all logic is rising-edge.
REQ-005 SHALL have port rst_ni, input, 1 bit, reset, asynchronous, active-low.
REQ-006 SHALL have port req_i, input, NUM_PORTS bits, per-port request.
REQ-007 SHALL have port we_i, input, NUM_PORTS bits, per-port write enable (1 = write).
REQ-008 SHALL have port be_i, input, NUM_PORTS x 4 bits, per-port byte enables.
REQ-009 SHALL have port addr_i, input, NUM_PORTS x 32 bits, per-port byte address.
REQ-010 SHALL have port wdata_i, input, NUM_PORTS x 32 bits, per-port write data.
REQ-011 SHALL have port gnt_o, output, NUM_PORTS bits, per-port grant.
REQ-012 SHALL have port rvalid_o, output, NUM_PORTS bits, per-port response valid.
REQ-013 SHALL have port rdata_o, output, NUM_PORTS x 32 bits, per-port read data.
REQ-014 SHALL have port err_o, output, NUM_PORTS bits, per-port error flag; present only with SRAM_ADDR_CHECK_EN.

Function
REQ-015 Storage SHALL be MEM_SIZE_BYTE/4 words of 32 bits, indexed by addr_i[log2(MEM_SIZE_BYTE)-1:2]; addr_i[1:0] and upper bits SHALL be ignored unless checking is enabled.
REQ-016 Each port SHALL run an independent FSM with states IDLE and RESP.
REQ-017 In IDLE, gnt_o SHALL equal req_i combinationally; a request is accepted at the edge where req_i and gnt_o are both 1, and the FSM SHALL move to RESP.
REQ-018 In RESP, rvalid_o SHALL be 1 for exactly one cycle.
REQ-019 With PIPELINED=0, gnt_o SHALL be 0 in RESP, and the FSM SHALL return to IDLE after RESP.
REQ-020 With PIPELINED=1, gnt_o SHALL equal req_i in RESP too, and a request accepted in RESP SHALL keep the FSM in RESP, giving one response per cycle.
REQ-021 Latency SHALL be exactly one cycle: rvalid_o is asserted in the cycle after acceptance, and responses SHALL be returned in order.
REQ-022 A write SHALL update only the bytes whose be_i bit is 1, at the acceptance edge; rdata_o SHALL be 0 for write responses.
REQ-023 A read SHALL capture the word at the acceptance edge and present it on rdata_o during rvalid_o; rdata_o SHALL be 0 whenever rvalid_o is 0.
REQ-024 On a simultaneous read and write to the same word at the same edge (same or different ports), the read SHALL return the pre-write data.
REQ-025 On simultaneous writes to the same word from several ports, each byte SHALL take the value from the highest-index port enabling that byte; all such requests SHALL still be granted and acknowledged.
REQ-026 A request with be_i = 0 SHALL be granted and acknowledged with no memory change.
REQ-027 The FSM SHALL not depend on address or write data; a held req_i SHALL be re-accepted per the REQ-019/REQ-020 rules.

Reset
REQ-028 While rst_ni = 0, every FSM SHALL be in IDLE and gnt_o, rvalid_o, rdata_o and err_o SHALL all be 0 (gnt_o gated low during reset).
REQ-029 Reset asserted mid-operation SHALL drop pending responses without emitting them; memory contents SHALL NOT be reset.
REQ-030 A write accepted at an edge before reset SHALL remain committed.

Configuration
REQ-031 With SRAM_ADDR_CHECK_EN defined, an access with any of addr_i[31:log2(MEM_SIZE_BYTE)] nonzero SHALL be granted, SHALL perform no write, SHALL return rdata_o = 0, and SHALL assert err_o together with rvalid_o.
REQ-032 Without SRAM_ADDR_CHECK_EN, err_o SHALL be absent and out-of-range addresses SHALL alias per REQ-015.

Verification
REQ-033 Port0 writes 0xDEADBEEF to 0x100 with be=0xF, then port1 reads 0x100 -> port1 rvalid one cycle after its gnt, rdata=0xDEADBEEF.
REQ-034 Word 0x40 holds 0x11223344; port0 writes be=0x2 with wdata=0xAAAAAAAA, then reads 0x40 -> rdata=0x1122AA44.
REQ-035 Same-edge write of 0x55555555 by port0 and read by port1 at 0x80, old value 0 -> port1 rdata=0; a later read returns 0x55555555.
REQ-036 Same-edge full-word writes to 0x20 by port0 (0x1) and port1 (0x2) -> both acknowledged; a later read returns 0x2.
REQ-037 PIPELINED=1 with 4 back-to-back reads on port0 -> gnt high for 4 cycles, 4 consecutive in-order rvalids; with PIPELINED=0 -> grants spaced 2 cycles apart.
REQ-038 Read accepted, then rst_ni pulsed low before rvalid -> no rvalid emitted; with SRAM_ADDR_CHECK_EN, a read of 0x0001_0000 at the default size -> err=1, rdata=0.

Source files
------------

// File: rtl/multi_port_sram_behavioral.sv
// Behavioural multi-port SRAM with independent OBI-style read/write ports.
// Each port runs a two-state IDLE/RESP handshake FSM with one-cycle latency.
// Optional feature: define SRAM_ADDR_CHECK_EN to flag out-of-range accesses on
// err_o (the port exists only in that build); without it, upper address bits alias.
module multi_port_sram_behavioral #(
  parameter int unsigned NUM_PORTS     = 2,
  parameter int unsigned MEM_SIZE_BYTE = 32768,
  parameter int unsigned PIPELINED     = 0
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [NUM_PORTS-1:0]      req_i,
  input  logic [NUM_PORTS-1:0]      we_i,
  input  logic [NUM_PORTS*4-1:0]    be_i,
  input  logic [NUM_PORTS*32-1:0]   addr_i,
  input  logic [NUM_PORTS*32-1:0]   wdata_i,
  output logic [NUM_PORTS-1:0]      gnt_o,
  output logic [NUM_PORTS-1:0]      rvalid_o,
  output logic [NUM_PORTS*32-1:0]   rdata_o
`ifdef SRAM_ADDR_CHECK_EN
  ,
  output logic [NUM_PORTS-1:0]      err_o
`endif
);

  localparam int unsigned NUM_WORDS = MEM_SIZE_BYTE / 4;
  localparam int unsigned ADDR_W    = $clog2(MEM_SIZE_BYTE);
  localparam int unsigned IDX_W     = ADDR_W - 2;
  localparam bit          PIPE_EN   = (PIPELINED != 0);

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_e;

  state_e               state_q [NUM_PORTS];
  state_e               state_d [NUM_PORTS];
  logic [NUM_PORTS-1:0] accept;
  logic [NUM_PORTS-1:0] addr_ok;
  logic [IDX_W-1:0]     word_idx [NUM_PORTS];
  logic [31:0]          mem_q    [NUM_WORDS];
  logic [31:0]          rdata_d  [NUM_PORTS];
  logic [31:0]          rdata_q  [NUM_PORTS];
  logic                 unused_addr_bits;

  // Byte-offset bits (and upper bits in the aliasing build) carry no meaning here.
  assign unused_addr_bits = ^addr_i;

  // Per-port word index and address range decode.
  always_comb begin
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      word_idx[p] = addr_i[p*32+2 +: IDX_W];
`ifdef SRAM_ADDR_CHECK_EN
      addr_ok[p]  = (addr_i[p*32+ADDR_W +: (32-ADDR_W)] == '0);
`else
      addr_ok[p]  = 1'b1;
`endif
    end
  end

  // FSM state register, one per port.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned p = 0; p < NUM_PORTS; p++) begin
        state_q[p] <= IDLE;
      end
    end else begin
      for (int unsigned p = 0; p < NUM_PORTS; p++) begin
        state_q[p] <= state_d[p];
      end
    end
  end

  // Next state: an accepted request always leads to a response cycle.
  always_comb begin
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      state_d[p] = state_q[p];
      unique case (state_q[p])
        IDLE:    if (accept[p]) state_d[p] = RESP;
        RESP:    state_d[p] = accept[p] ? RESP : IDLE;
        default: state_d[p] = IDLE;
      endcase
    end
  end

  // FSM outputs: grant follows request when the port can take it, gated in reset.
  always_comb begin
    gnt_o    = '0;
    rvalid_o = '0;
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      gnt_o[p]    = req_i[p] & rst_ni & ((state_q[p] == IDLE) | PIPE_EN);
      rvalid_o[p] = (state_q[p] == RESP);
    end
  end

  assign accept = req_i & gnt_o;

  // Read data captured at the acceptance edge; zero for writes and idle cycles.
  always_comb begin
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      rdata_d[p] = '0;
      if (accept[p] && !we_i[p] && addr_ok[p]) begin
        rdata_d[p] = mem_q[word_idx[p]];
      end
    end
  end

  // Response data register; cleared so pending responses vanish on reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned p = 0; p < NUM_PORTS; p++) begin
        rdata_q[p] <= '0;
      end
    end else begin
      for (int unsigned p = 0; p < NUM_PORTS; p++) begin
        rdata_q[p] <= rdata_d[p];
      end
    end
  end

  // Flatten per-port read data onto the output bus.
  always_comb begin
    rdata_o = '0;
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      rdata_o[p*32 +: 32] = rdata_q[p];
    end
  end

  // Storage write: ascending port order so the highest-index enabling port wins each byte.
  always_ff @(posedge clk_i) begin
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (accept[p] && we_i[p] && addr_ok[p] && be_i[p*4+b]) begin
          mem_q[word_idx[p]][b*8 +: 8] <= wdata_i[p*32+b*8 +: 8];
        end
      end
    end
  end

`ifdef SRAM_ADDR_CHECK_EN
  logic [NUM_PORTS-1:0] err_q;

  // Error flag travels with the response of an out-of-range access.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_q <= '0;
    end else begin
      err_q <= accept & ~addr_ok;
    end
  end

  assign err_o = err_q;
`endif

endmodule
